// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl
// Shares one sequential shift-add multiplier between NREQ requesters.
// A round-robin arbiter picks one request in IDLE. The operands are latched.
// One partial product is added per cycle for WIDTH cycles. The product is then
// held on a valid/ready response channel together with the requester index.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req_valid     per-requester request valid                  [NREQ]
//   req_ready     per-requester accept, one-hot or zero        [NREQ]
//   req_a/req_b   packed operands, slot i at [i*WIDTH +: WIDTH] [NREQ*WIDTH]
//   resp_valid    product available
//   resp_ready    consumer accepts product
//   resp_product  unsigned a*b                                 [2*WIDTH]
//   resp_id       index of the requester that owns the result  [ID_W]
//   busy          high whenever the controller is not idle
module mult_share_ctrl #(
  parameter int WIDTH = 3,
  parameter int NREQ  = 2,
  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [2*WIDTH-1:0]    resp_product,
  output logic [ID_W-1:0]       resp_id,
  output logic                  busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      id_r;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   partial;
  logic                 grant_found;
  logic [ID_W-1:0]      grant_idx;
  logic [ID_W-1:0]      next_ptr;

  // Round-robin search starting at rr_ptr. The loop runs from the farthest
  // offset down to offset 0, so the last hit written is the nearest one.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  // Only the granted slot sees ready, and only while idle.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  // Shifted copy of A when the current multiplier bit is set. Everything is
  // zero-extended to the full product width, so no carry is ever lost.
  always_comb begin
    partial = '0;
    if (b_r[cnt]) partial = {{WIDTH{1'b0}}, a_r} << cnt;
  end

  // After serving id_r, the pointer moves to the slot after it, wrapping at NREQ.
  always_comb begin
    next_ptr = id_r + 1'b1;
    if (id_r == ID_W'(NREQ - 1)) next_ptr = '0;
  end

  assign resp_product = acc;
  assign resp_id      = id_r;

  // Controller FSM. resp_valid and busy are registered alongside the state so
  // that reset clears them immediately and they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id_r       <= '0;
      cnt        <= '0;
      a_r        <= '0;
      b_r        <= '0;
      acc        <= '0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            a_r   <= req_a[grant_idx*WIDTH +: WIDTH];
            b_r   <= req_b[grant_idx*WIDTH +: WIDTH];
            id_r  <= grant_idx;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= MUL;
          end
        end
        MUL: begin
          acc <= acc + partial;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            rr_ptr     <= next_ptr;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Sequential shift-add multiplier controller that shares one small unsigned multiplier datapath between NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. A round-robin arbiter grants one request at a time. The controller sequences one partial product per cycle into a 2*WIDTH accumulator and returns the product with the requester's ID over a valid/ready response channel. It sits between the client blocks and the multiplier datapath, replacing per-client combinational multipliers.

## Interface
- WIDTH, 3, operand width in bits (unsigned); product is 2*WIDTH bits
- NREQ, 2, number of requesters (>=1)
- ID_W (derived, not overridable), NREQ>1 ? $clog2(NREQ) : 1, width of resp_id

- clk  in  1  rising-edge clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_a  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B, same packing
- resp_valid  out  1  product available
- resp_ready  in  1  consumer accepts product
- resp_product  out  2*WIDTH  a*b, unsigned, exact
- resp_id  out  ID_W  index of the requester that produced this result
- busy  out  1  high in MUL or DONE

## Operation
- FSM states:
  - IDLE: arbitrate. Accept when any req_valid is high.
  - MUL: accumulate one partial product per cycle.
  - DONE: hold the result until it is consumed.
- Round-robin pointer rr_ptr (reset 0). Grant goes to the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … with wrap at NREQ.
- req_ready[g] is high combinationally only in IDLE and only for the granted g. It is zero in MUL/DONE and zero when no valid is present.
- On accept (IDLE, req_valid[g] & req_ready[g]):
  - latch a_r, b_r from slot g; latch id_r=g
  - clear acc (2*WIDTH bits); cnt=0; go to MUL
- MUL, each cycle:
  - acc <= acc + (b_r[cnt] ? ({WIDTH'b0,a_r} << cnt) : 0); cnt++
  - after the cycle with cnt=WIDTH-1, go to DONE
- Arithmetic: all zero-extended to 2*WIDTH. The maximum (2^WIDTH-1)^2 fits, so no overflow and no truncation is permitted.
- DONE:
  - resp_valid=1; resp_product=acc; resp_id=id_r
  - on resp_valid & resp_ready: rr_ptr <= (id_r+1) mod NREQ, go to IDLE
- Operands are latched, so the requester may change req_a/req_b immediately after its handshake.
- Requesters must hold req_valid and operands stable until ready. A req_valid dropped before grant is simply not served.

## Timing
- Reset (async assert, sync deassert by the system):
  - state=IDLE, rr_ptr=0, cnt=0, acc=0, id_r=0
  - resp_valid=0, resp_product=0, resp_id=0, busy=0
- Latency: accept at edge E0. resp_valid is high from edge E0+WIDTH (exactly WIDTH cycles later).
- Throughput: a new accept happens no earlier than the IDLE cycle following the response handshake. Minimum period is WIDTH+2 cycles with resp_ready tied high.
- Backpressure: while resp_valid & !resp_ready, resp_product and resp_id hold stable. No new request is accepted.
- Simultaneous valids: the grant is decided in the same IDLE cycle; only one req_ready is high.
- rr_ptr wraps from NREQ-1 to 0. With NREQ=1, rr_ptr stays 0.
- Reset mid-MUL or mid-DONE: the operation is abandoned and no response is issued. resp_valid falls immediately (asynchronously).
- busy=0 exactly when state=IDLE.

## Test plan
- Single request, WIDTH=3: req0 a=5, b=7 -> req_ready[0] high one cycle; resp_valid 3 cycles after accept; resp_product=35, resp_id=0.
- Boundary operands: a=7,b=7 -> 49; a=0,b=6 -> 0; a=6,b=0 -> 0; a=1,b=1 -> 1. Also an exhaustive 64-pair sweep against a reference model.
- Arbitration after reset: req0 (3,4) and req1 (2,5) both valid in the same cycle -> req0 served first (12, id 0), then req1 (10, id 1).
- Fairness: req0 and req1 held valid continuously for 6 transactions -> grant order 0,1,0,1,0,1.
- Backpressure: resp_ready low for 5 cycles on product 42 (6*7) -> resp_valid stays high; product/id stable; req_ready stays 0; completes on the first resp_ready=1 cycle.
- Reset mid-operation: assert rst_n=0 two cycles into MUL -> all outputs 0 immediately, no response. A subsequent req1 (7,3) -> 21, id 1, with rr_ptr restarted at 0.
